// File: rtl/cache_arb_pkg.sv
// Shared definitions for the cache/memory burst arbiter: state encoding,
// default geometry derived from the cache line size, requester indices.
package cache_arb_pkg;

    // Cache line is 2**CACHE_B bytes, so a line holds 2**(CACHE_B-2) words.
    localparam int CACHE_B       = 5;
    localparam int DEF_N_REQ     = 2;
    localparam int DEF_BURST_LEN = 2 ** (CACHE_B - 2);

    localparam int REQ_ICACHE = 0;
    localparam int REQ_DCACHE = 1;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle between cache controllers, the arbiter and the memory port.
// slave = arbiter view, master = cache controllers plus memory model view.
interface cache_mem_arbiter_if #(
    parameter int N_REQ = cache_arb_pkg::DEF_N_REQ
);
    // Handshake: a beat transfers in any cycle where mem_valid and mem_ready
    // are both high; ready[i] mirrors that transfer back to the owning cache.
    logic                    en;
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        lock;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*32-1:0]     addr;
    logic [N_REQ*32-1:0]     wdata;
    logic [N_REQ-1:0]        grant;
    logic [N_REQ-1:0]        ready;
    logic [31:0]             count;
    logic [31:0]             rdata;
    logic                    mem_valid;
    logic                    mem_we;
    logic [31:0]             mem_addr;
    logic [31:0]             mem_wdata;
    logic                    mem_ready;
    logic [31:0]             mem_rdata;
    cache_arb_pkg::arb_state_e dbg_state;

    modport slave (
        input  en, req, lock, we, addr, wdata, mem_ready, mem_rdata,
        output grant, ready, count, rdata, mem_valid, mem_we, mem_addr,
               mem_wdata, dbg_state
    );

    modport master (
        output en, req, lock, we, addr, wdata, mem_ready, mem_rdata,
        input  grant, ready, count, rdata, mem_valid, mem_we, mem_addr,
               mem_wdata, dbg_state
    );
endinterface

// File: rtl/cache_mem_arbiter_rr_picker.sv
// Combinational round-robin search: first requester with req set, starting
// at the rr pointer and wrapping modulo N_REQ.
module rr_picker #(
    parameter int N_REQ = 2,
    localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    rr_i,
    output logic             valid_o,
    output logic [IW-1:0]    idx_o
);
    always_comb begin
        int j;
        valid_o = 1'b0;
        idx_o   = '0;
        j       = 0;
        // Scan from the farthest offset back so the nearest hit wins.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            j = (int'(rr_i) + off) % N_REQ;
            if (req_i[IW'(j)]) begin
                valid_o = 1'b1;
                idx_o   = IW'(j);
            end
        end
    end
endmodule

// File: rtl/cache_mem_arbiter.sv
// Grants whole BURST_LEN-beat bursts on one memory port to N_REQ cache
// controllers in round-robin order and supplies the shared beat counter.
module cache_mem_arbiter import cache_arb_pkg::*; #(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int CW        = $clog2(BURST_LEN)
) (
    input logic               clk,
    input logic               reset,
    cache_mem_arbiter_if.slave bus
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic           pick_valid;
    logic [IW-1:0]  pick_idx;
    logic           busy;
    logic           beat;
    logic           last_beat;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_i   (bus.req),
        .rr_i    (rr_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign busy          = (state_q == ARB_BUSY);
    // A dropped req mid-burst stalls the burst rather than ending it.
    assign bus.mem_valid = busy & bus.en & bus.req[owner_q];
    assign beat          = bus.mem_valid & bus.mem_ready;
    assign last_beat     = (cnt_q == CW'(BURST_LEN - 1));

    assign bus.count     = 32'(cnt_q);
    assign bus.rdata     = bus.mem_rdata;
    assign bus.dbg_state = state_q;

    always_comb begin
        bus.grant     = '0;
        bus.ready     = '0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (busy) begin
            bus.grant[owner_q] = 1'b1;
            bus.ready[owner_q] = beat;
            bus.mem_we         = bus.we[owner_q];
            bus.mem_addr       = bus.addr[int'(owner_q) * 32 +: 32];
            bus.mem_wdata      = bus.wdata[int'(owner_q) * 32 +: 32];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (bus.en) begin
            case (state_q)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state_d = ARB_BUSY;
                        owner_d = pick_idx;
                        cnt_d   = '0;
                    end
                end
                ARB_BUSY: begin
                    if (beat) begin
                        // BURST_LEN is a power of two, so the add wraps to 0.
                        cnt_d = cnt_q + CW'(1);
                        if (last_beat && !bus.lock[owner_q]) begin
                            state_d = ARB_IDLE;
                            rr_d    = IW'(rr_next(int'(owner_q), N_REQ));
                        end
                    end
                end
                default: state_d = ARB_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
